// File: rtl/fp_add_pkg.sv
// Shared types and constants for the FP adder control path.
// Contents: state_t (sequencer states), EXP_W / MANT_W widths, exp_abs_diff helper.
package fp_add_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 24;

    typedef enum logic [2:0] {
        IDLE,
        DIFF,
        SHIFT,
        ADD,
        NORM,
        DONE
    } state_t;

    // Unsigned |a - b| without wrap.
    function automatic logic [EXP_W-1:0] exp_abs_diff(input logic [EXP_W-1:0] a,
                                                      input logic [EXP_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/align_counter.sv
// Alignment down counter: loads a shift amount, decrements on request, holds at zero.
// Ports: clk, rst (sync, active-high), load/load_val, dec, count (registered), zero_c (comb).
module align_counter #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero_c
);

    assign zero_c = (count == '0);

    // Load wins over decrement; decrement saturates at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero_c) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/fp_align_sequencer.sv
// Control sequencer for the FP adder datapath: exponent compare, alignment shift
// stepping, add strobe and post-add normalization stepping. All outputs registered.
// Ports: Clk, Reset (sync, active-high), Start, ExpA/ExpB, SumCarry/SumMsb/SumZero in;
//        Busy, Swap, ShiftCount, ShiftEn, AddEn, NormRight, NormLeft, Done out.
// Build option: define ALIGN_SKIP_EN to bypass SHIFT when the alignment count is zero.
module fp_align_sequencer
    import fp_add_pkg::*;
#(
    parameter int unsigned CNT_W      = 5,
    parameter int unsigned MAX_SHIFT  = 25,
    parameter int unsigned NORM_LIMIT = MANT_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [EXP_W-1:0] ExpA,
    input  logic [EXP_W-1:0] ExpB,
    input  logic             SumCarry,
    input  logic             SumMsb,
    input  logic             SumZero,
    output logic             Busy,
    output logic             Swap,
    output logic [CNT_W-1:0] ShiftCount,
    output logic             ShiftEn,
    output logic             AddEn,
    output logic             NormRight,
    output logic             NormLeft,
    output logic             Done
);

    localparam int unsigned NCNT_W = $clog2(NORM_LIMIT + 1);

    state_t            state, next_state;
    logic [CNT_W-1:0]  diff_q, diff_sat_c;
    logic [EXP_W-1:0]  diff_raw_c;
    logic [NCNT_W-1:0] left_cnt_q;
    logic              norm_first_q, right_pend_q;
    logic              accept_c, carry_hit_c, left_ok_c;
    logic              cnt_load_c, cnt_dec_c, cnt_zero_c;
    logic              busy_c, shift_en_c, add_en_c, norm_right_c, norm_left_c, done_c;

    // Start is taken only when fully idle, including the Done cycle (Busy still high).
    assign accept_c = (state == IDLE) && !Busy && Start;

    // Saturated exponent difference; anything beyond MAX_SHIFT flushes the mantissa anyway.
    assign diff_raw_c = exp_abs_diff(ExpA, ExpB);
    assign diff_sat_c = (diff_raw_c > EXP_W'(MAX_SHIFT)) ? CNT_W'(MAX_SHIFT) : CNT_W'(diff_raw_c);

    // Normalization decisions; carry only matters on the first NORM cycle.
    assign carry_hit_c = norm_first_q && SumCarry;
    assign left_ok_c   = !SumMsb && (left_cnt_q < NCNT_W'(NORM_LIMIT));

    assign cnt_load_c = (state == DIFF);
    assign cnt_dec_c  = (state == SHIFT);

    align_counter #(
        .CNT_W(CNT_W)
    ) u_align_counter (
        .clk     (Clk),
        .rst     (Reset),
        .load    (cnt_load_c),
        .load_val(diff_q),
        .dec     (cnt_dec_c),
        .count   (ShiftCount),
        .zero_c  (cnt_zero_c)
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (accept_c) next_state = DIFF;
`ifdef ALIGN_SKIP_EN
            DIFF:  next_state = (diff_q == '0) ? ADD : SHIFT;
`else
            DIFF:  next_state = SHIFT;
`endif
            SHIFT: if (ShiftCount <= CNT_W'(1)) next_state = ADD;
            ADD:   next_state = NORM;
            NORM: begin
                if (right_pend_q || SumZero)   next_state = DONE;
                else if (carry_hit_c)          next_state = NORM;
                else if (left_ok_c)            next_state = NORM;
                else                           next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode, registered below.
    always_comb begin
        busy_c       = (state != IDLE);
        shift_en_c   = (state == SHIFT) && !cnt_zero_c;
        add_en_c     = (state == ADD);
        norm_right_c = 1'b0;
        norm_left_c  = 1'b0;
        done_c       = (state == DONE);
        if ((state == NORM) && !right_pend_q && !SumZero) begin
            norm_right_c = carry_hit_c;
            norm_left_c  = !carry_hit_c && left_ok_c;
        end
    end

    // Output registers and operation context.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Busy         <= 1'b0;
            Swap         <= 1'b0;
            ShiftEn      <= 1'b0;
            AddEn        <= 1'b0;
            NormRight    <= 1'b0;
            NormLeft     <= 1'b0;
            Done         <= 1'b0;
            diff_q       <= '0;
            left_cnt_q   <= '0;
            norm_first_q <= 1'b0;
            right_pend_q <= 1'b0;
        end else begin
            Busy         <= busy_c;
            ShiftEn      <= shift_en_c;
            AddEn        <= add_en_c;
            NormRight    <= norm_right_c;
            NormLeft     <= norm_left_c;
            Done         <= done_c;
            norm_first_q <= (state == ADD);
            right_pend_q <= norm_right_c;
            if (accept_c) begin
                Swap   <= (ExpB > ExpA);
                diff_q <= diff_sat_c;
            end
            if (state == ADD) begin
                left_cnt_q <= '0;
            end else if (norm_left_c) begin
                left_cnt_q <= left_cnt_q + NCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fp_align_sequencer.sv
// Self-checking bench for fp_align_sequencer: directed and randomized operations
// compared against an operation-level reference model.
module tb_fp_align_sequencer;

    logic       Clk = 1'b0;
    logic       Reset, Start;
    logic [7:0] ExpA, ExpB;
    logic       SumCarry, SumMsb, SumZero;
    logic       Busy, Swap, ShiftEn, AddEn, NormRight, NormLeft, Done;
    logic [4:0] ShiftCount;

`ifdef ALIGN_SKIP_EN
    localparam int SKIP = 1;
`else
    localparam int SKIP = 0;
`endif
    localparam int MAXS  = 25;
    localparam int NLIM  = 24;

    int n_cmp = 0;
    int n_bad = 0;

    // observations from one operation
    int   o_done_cyc, o_se, o_se_runs, o_max_cnt, o_add, o_nr, o_nl, o_both;
    int   o_swap_var, o_busy_bad, o_post;
    logic o_swap;
    // expectations from the model
    int   e_lat, e_shift, e_l, e_r;
    logic e_swap;

    fp_align_sequencer dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ExpA(ExpA), .ExpB(ExpB),
        .SumCarry(SumCarry), .SumMsb(SumMsb), .SumZero(SumZero),
        .Busy(Busy), .Swap(Swap), .ShiftCount(ShiftCount), .ShiftEn(ShiftEn),
        .AddEn(AddEn), .NormRight(NormRight), .NormLeft(NormLeft), .Done(Done)
    );

    always #5 Clk = ~Clk;

    // Operation-level reference: cycles spent per phase, plus one output-register cycle.
    function automatic void model(input int a, input int b, input logic c, input logic m,
                                  input logic z);
        int d, s;
        d       = (a > b) ? a - b : b - a;
        e_shift = (d > MAXS) ? MAXS : d;
        if (SKIP == 1 && e_shift == 0) s = 0;
        else                           s = (e_shift == 0) ? 1 : e_shift;
        e_l = 0;
        e_r = 0;
        if (z)       begin e_l = 0; e_r = 0; end
        else if (c)  e_r = 1;
        else if (!m) e_l = NLIM;
        e_swap = (b > a);
        // DIFF + SHIFT(s) + ADD + NORM(1+L+R) + DONE, then Done appears one cycle later
        e_lat = 1 + s + 1 + (1 + e_l + e_r) + 1 + 1;
    endfunction

    // Launch one operation and collect what the DUT did; Start is toggled randomly while busy.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic m, input logic z);
        logic prev_se;
        @(negedge Clk);
        ExpA = a; ExpB = b; SumCarry = c; SumMsb = m; SumZero = z; Start = 1'b1;
        o_done_cyc = -1; o_se = 0; o_se_runs = 0; o_max_cnt = 0; o_add = 0; o_nr = 0;
        o_nl = 0; o_both = 0; o_swap_var = 0; o_busy_bad = 0; o_post = 0; o_swap = 1'bx;
        prev_se = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge Clk);
            if (ShiftEn) begin
                o_se++;
                if (!prev_se) o_se_runs++;
            end
            prev_se = ShiftEn;
            if (int'(ShiftCount) > o_max_cnt) o_max_cnt = int'(ShiftCount);
            if (AddEn) o_add++;
            if (NormRight) o_nr++;
            if (NormLeft) o_nl++;
            if (NormRight && NormLeft) o_both++;
            if (cyc == 1) o_swap = Swap;
            else if (Swap !== o_swap) o_swap_var++;
            if (Busy !== (cyc >= 2)) o_busy_bad++;
            if (Done) begin
                o_done_cyc = cyc;
                break;
            end
            Start = 1'($urandom_range(0, 1));
        end
        Start = 1'($urandom_range(0, 1));
        @(negedge Clk);
        Start = 1'b0;
        if (Busy || Done) o_post++;
        @(negedge Clk);
        if (Busy || Done) o_post++;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; ExpA = '0; ExpB = '0;
        SumCarry = 1'b0; SumMsb = 1'b0; SumZero = 1'b0;
        repeat (3) @(negedge Clk);
        n_cmp++;
        if ({Busy, Swap, ShiftCount, ShiftEn, AddEn, NormRight, NormLeft, Done} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {Busy, Swap, ShiftCount, ShiftEn, AddEn, NormRight, NormLeft, Done});
        end
        Reset = 1'b0;
    endtask

    // Alignment path: exponent patterns with a plain normalized sum.
    task automatic test_align();
        logic [7:0] ta [8] = '{8'h85, 8'h10, 8'h7F, 8'h80, 8'h20, 8'h00, 8'h40, 8'hFF};
        logic [7:0] tb [8] = '{8'h80, 8'h90, 8'h7F, 8'h85, 8'h39, 8'h1A, 8'h41, 8'h00};
        logic [7:0] a, b;
        for (int i = 0; i < 38; i++) begin
            if (i < 8) begin a = ta[i]; b = tb[i]; end
            else begin
                a = 8'($urandom_range(0, 255));
                b = (i % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'(a + 8'($urandom_range(0, 30)));
            end
            model(int'(a), int'(b), 1'b0, 1'b1, 1'b0);
            run_op(a, b, 1'b0, 1'b1, 1'b0);
            n_cmp++;
            if (o_done_cyc !== e_lat) begin
                n_bad++; $display("FAIL align[%0d] latency: got %0d required %0d", i, o_done_cyc, e_lat);
            end
            n_cmp++;
            if (o_se !== e_shift) begin
                n_bad++; $display("FAIL align[%0d] shift_en_count: got %0d required %0d", i, o_se, e_shift);
            end
            n_cmp++;
            if (o_se_runs !== ((e_shift > 0) ? 1 : 0)) begin
                n_bad++; $display("FAIL align[%0d] shift_contiguous: got %0d runs", i, o_se_runs);
            end
            n_cmp++;
            if (o_max_cnt !== e_shift) begin
                n_bad++; $display("FAIL align[%0d] shift_count_load: got %0d required %0d", i, o_max_cnt, e_shift);
            end
            n_cmp++;
            if (o_swap !== e_swap || o_swap_var !== 0) begin
                n_bad++; $display("FAIL align[%0d] swap: got %b (changed %0d times) required %b", i, o_swap, o_swap_var, e_swap);
            end
            n_cmp++;
            if (o_add !== 1 || o_nr !== 0 || o_nl !== 0) begin
                n_bad++; $display("FAIL align[%0d] strobes: add %0d right %0d left %0d required 1/0/0", i, o_add, o_nr, o_nl);
            end
            n_cmp++;
            if (o_busy_bad !== 0 || o_post !== 0) begin
                n_bad++; $display("FAIL align[%0d] busy_or_start_ignore: bad busy %0d, post-done activity %0d", i, o_busy_bad, o_post);
            end
        end
    endtask

    // Normalization path: carry, leading zeros, zero sum and random mixes.
    task automatic test_norm();
        logic tc [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic tm [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic tz [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic c, m, z;
        logic [7:0] a, b;
        for (int i = 0; i < 20; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'(a ^ 8'($urandom_range(0, 7)));
            if (i < 4) begin c = tc[i]; m = tm[i]; z = tz[i]; end
            else begin
                c = 1'($urandom_range(0, 1));
                m = 1'($urandom_range(0, 1));
                z = ($urandom_range(0, 3) == 0);
            end
            model(int'(a), int'(b), c, m, z);
            run_op(a, b, c, m, z);
            n_cmp++;
            if (o_done_cyc !== e_lat) begin
                n_bad++; $display("FAIL norm[%0d] latency: got %0d required %0d", i, o_done_cyc, e_lat);
            end
            n_cmp++;
            if (o_nr !== e_r) begin
                n_bad++; $display("FAIL norm[%0d] norm_right: got %0d required %0d", i, o_nr, e_r);
            end
            n_cmp++;
            if (o_nl !== e_l) begin
                n_bad++; $display("FAIL norm[%0d] norm_left: got %0d required %0d", i, o_nl, e_l);
            end
            n_cmp++;
            if (o_both !== 0 || o_add !== 1 || o_post !== 0) begin
                n_bad++; $display("FAIL norm[%0d] exclusivity: both %0d add %0d post %0d required 0/1/0", i, o_both, o_add, o_post);
            end
        end
    endtask

    // Reset in the middle of the alignment shift aborts cleanly.
    task automatic test_abort();
        logic found;
        found = 1'b0;
        @(negedge Clk);
        ExpA = 8'h4A; ExpB = 8'h40; SumCarry = 1'b0; SumMsb = 1'b1; SumZero = 1'b0; Start = 1'b1;
        for (int cyc = 1; cyc <= 30 && !found; cyc++) begin
            @(negedge Clk);
            Start = 1'b0;
            if (ShiftCount == 5'd7) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++; $display("FAIL abort_reach_count7: got %0d never reached required 7", ShiftCount);
        end
        Reset = 1'b1;
        @(negedge Clk);
        n_cmp++;
        if ({Busy, Swap, ShiftCount, ShiftEn, AddEn, NormRight, NormLeft, Done} !== 12'h000) begin
            n_bad++; $display("FAIL abort_clear: got %b required all zero",
                              {Busy, Swap, ShiftCount, ShiftEn, AddEn, NormRight, NormLeft, Done});
        end
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        n_cmp++;
        if ({Busy, ShiftCount, ShiftEn, AddEn, NormRight, NormLeft, Done} !== 11'h000) begin
            n_bad++; $display("FAIL abort_no_resume: got %b required all zero",
                              {Busy, ShiftCount, ShiftEn, AddEn, NormRight, NormLeft, Done});
        end
    endtask

    // Consecutive operations with differing shapes keep independent timing.
    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            logic [7:0] a, b;
            logic c, z;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            c = (i % 3 == 1);
            z = (i % 3 == 2);
            model(int'(a), int'(b), c, 1'b1, z);
            run_op(a, b, c, 1'b1, z);
            n_cmp++;
            if (o_done_cyc !== e_lat || o_se !== e_shift || o_nr !== e_r) begin
                n_bad++; $display("FAIL b2b[%0d] op: lat %0d/%0d shifts %0d/%0d right %0d/%0d (got/required)",
                                  i, o_done_cyc, e_lat, o_se, e_shift, o_nr, e_r);
            end
        end
    endtask

    initial begin
        test_reset();
        test_align();
        test_norm();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
